seg_capture: RTL and testbench

SEG_CAPTURE -- requirements
Module: seg_capture

---
 rtl/seg_capture.sv | 171 +++++++++++++++++
 tb/tb_seg_capture.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg_capture
// Brief    : Decodes a multiplexed 4-digit 7-segment display bus into a value.
// Revision : 1.0
// ============================================================================
module seg_capture #(
    parameter int STABLE_FRAMES = 2
) (
    input  logic        seg_clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [13:0] pts,
    output logic        pts_valid,
    output logic        pts_stable,
    output logic        frame_err
);

    // State value equals the number of digits already latched.
    localparam logic [1:0] c_HUNT = 2'd0;
    localparam logic [1:0] c_GOT0 = 2'd1;
    localparam logic [1:0] c_GOT1 = 2'd2;
    localparam logic [1:0] c_GOT2 = 2'd3;
    localparam logic [3:0] c_STABLE = 4'(STABLE_FRAMES);

    logic [3:0]  r_an;
    logic [3:0]  r_prev_an;
    logic [7:0]  r_seg;
    logic [1:0]  r_state;
    logic [3:0]  r_d0, r_d1, r_d2, r_d3;
    logic        r_complete;
    logic [3:0]  r_count;

    logic [3:0]  w_val;
    logic        w_pat_ok;
    logic [1:0]  w_idx;
    logic        w_is_digit;
    logic        w_idle;
    logic        w_new;
    logic        w_good;
    logic        w_accept;
    logic        w_restart;
    logic        w_reject;
    logic        w_err;
    logic [13:0] w_frame;
    logic [3:0]  w_count_next;

    always_ff @(posedge seg_clk) begin
        if (reset) begin
            r_an      <= 4'b1111;
            r_prev_an <= 4'b1111;
            r_seg     <= 8'hFF;
        end else begin
            r_an      <= an;
            r_prev_an <= r_an;
            r_seg     <= seg;
        end
    end

    always_comb begin
        w_val    = 4'd0;
        w_pat_ok = 1'b1;
        case (r_seg[6:0])
            7'b1000000: w_val = 4'd0;
            7'b1111001: w_val = 4'd1;
            7'b0100100: w_val = 4'd2;
            7'b0110000: w_val = 4'd3;
            7'b0011001: w_val = 4'd4;
            7'b0010010: w_val = 4'd5;
            7'b0000010: w_val = 4'd6;
            7'b1111000: w_val = 4'd7;
            7'b0000000: w_val = 4'd8;
            7'b0010000: w_val = 4'd9;
            default:    w_pat_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_idx      = 2'd0;
        w_is_digit = 1'b1;
        case (r_an)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_is_digit = 1'b0;
        endcase
    end

    // A held anode is one strobe; only its first cycle counts.
    assign w_idle    = (r_an == 4'b1111);
    assign w_new     = w_is_digit && (r_an != r_prev_an);
    assign w_good    = w_pat_ok && r_seg[7];
    assign w_accept  = w_new && (w_idx == r_state) && w_good;
    assign w_restart = w_new && (w_idx == 2'd0) && w_good;
    assign w_reject  = (w_new && !w_accept) || (!w_is_digit && !w_idle);
    assign w_err     = (r_state != c_HUNT) && w_reject;

    always_ff @(posedge seg_clk) begin
        if (reset) begin
            r_state    <= c_HUNT;
            r_d0       <= 4'd0;
            r_d1       <= 4'd0;
            r_d2       <= 4'd0;
            r_d3       <= 4'd0;
            r_complete <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_complete <= 1'b0;
            frame_err  <= 1'b0;
            if (w_accept) begin
                case (w_idx)
                    2'd0:    r_d0 <= w_val;
                    2'd1:    r_d1 <= w_val;
                    2'd2:    r_d2 <= w_val;
                    default: r_d3 <= w_val;
                endcase
                if (r_state == c_GOT2) begin
                    r_complete <= 1'b1;
                    r_state    <= c_HUNT;
                end else begin
                    r_state <= r_state + 2'd1;
                end
            end else if (w_err) begin
                frame_err <= 1'b1;
                if (w_restart) begin
                    r_d0    <= w_val;
                    r_state <= c_GOT0;
                end else begin
                    r_state <= c_HUNT;
                end
            end
        end
    end

    assign w_frame = 14'(r_d3) * 14'd1000 + 14'(r_d2) * 14'd100
                   + 14'(r_d1) * 14'd10 + 14'(r_d0);

    // pts still holds the previous completed frame when a new one converts.
    always_comb begin
        w_count_next = r_count;
        if (w_err) begin
            w_count_next = 4'd0;
        end else if (r_complete) begin
            if (w_frame == pts) begin
                w_count_next = (r_count < c_STABLE) ? r_count + 4'd1 : c_STABLE;
            end else begin
                w_count_next = 4'd1;
            end
        end
    end

    always_ff @(posedge seg_clk) begin
        if (reset) begin
            pts        <= 14'd0;
            pts_valid  <= 1'b0;
            pts_stable <= 1'b0;
            r_count    <= 4'd0;
        end else begin
            pts_valid  <= r_complete && !w_err;
            if (r_complete && !w_err) begin
                pts <= w_frame;
            end
            r_count    <= w_count_next;
            pts_stable <= (w_count_next == c_STABLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_capture
// Brief    : Directed table, hand sequences and random frames for seg_capture.
// Revision : 1.0
// ============================================================================
module tb_seg_capture;

    localparam int c_S  = 2;
    localparam int c_L  = 600;
    localparam int c_LT = c_L + 4;

    logic        seg_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [3:0]  an      = 4'hF;
    logic [7:0]  seg     = 8'hFF;
    logic [13:0] pts;
    logic        pts_valid;
    logic        pts_stable;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int nv       = 0;
    int ne       = 0;
    int vcyc     = -1;

    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic       valid;
        logic       err;
        int         pts;
        logic       stable;
    } vec_t;

    vec_t tbl [25];

    logic [3:0] ran  [c_LT];
    logic [7:0] rseg [c_LT];
    logic       e_pset [c_LT + 3];
    int         e_pval [c_LT + 3];
    logic       e_err  [c_LT + 3];
    logic       e_sset [c_LT + 3];
    logic       e_sval [c_LT + 3];

    seg_capture #(.STABLE_FRAMES(c_S)) dut (
        .seg_clk    (seg_clk),
        .reset      (reset),
        .an         (an),
        .seg        (seg),
        .pts        (pts),
        .pts_valid  (pts_valid),
        .pts_stable (pts_stable),
        .frame_err  (frame_err)
    );

    always #5 seg_clk = ~seg_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] dg(int d);
        return {1'b1, pat[d]};
    endfunction

    function automatic int decode(logic [6:0] x);
        for (int d = 0; d < 10; d++) if (x == pat[d]) return d;
        return -1;
    endfunction

    function automatic logic [31:0] pack(logic v, logic e, logic s, int p);
        return {15'd0, v, e, s, p[13:0]};
    endfunction

    function automatic vec_t mk(logic [3:0] a, logic [7:0] s, logic v, logic e, int p, logic st);
        vec_t r;
        r.an = a; r.seg = s; r.valid = v; r.err = e; r.pts = p; r.stable = st;
        return r;
    endfunction

    task automatic tick();
        @(posedge seg_clk);
        #1;
        cyc++;
        if (pts_valid) begin nv++; vcyc = cyc; end
        if (frame_err) ne++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        an = 4'hF; seg = 8'hFF;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Later cycles of a held strobe carry junk segments that must be ignored.
    task automatic send_frame(input int v, input int reps, input int gap, output int t3);
        int pw;
        t3 = -1;
        for (int k = 0; k < 4; k++) begin
            pw = 1;
            for (int j = 0; j < k; j++) pw *= 10;
            for (int r = 0; r < reps; r++) begin
                an  = ~(4'b0001 << k);
                seg = (r == 0) ? dg((v / pw) % 10) : 8'hFF;
                tick();
                if (k == 3 && r == 0) t3 = cyc;
            end
            idle(gap);
        end
        idle(3);
    endtask

    initial begin
        int t3, nv0, ne0;
        tbl[0]  = mk(4'hE, dg(4), 0, 0, 0, 0);
        tbl[1]  = mk(4'hD, dg(3), 0, 0, 0, 0);
        tbl[2]  = mk(4'hB, dg(2), 0, 0, 0, 0);
        tbl[3]  = mk(4'h7, dg(1), 0, 0, 0, 0);
        tbl[4]  = mk(4'hF, 8'hFF, 0, 0, 0, 0);
        tbl[5]  = mk(4'hF, 8'hFF, 1, 0, 1234, 0);
        tbl[6]  = mk(4'hF, 8'hFF, 0, 0, 1234, 0);
        tbl[7]  = mk(4'hE, dg(5), 0, 0, 1234, 0);
        tbl[8]  = mk(4'hD, dg(6), 0, 0, 1234, 0);
        tbl[9]  = mk(4'hB, 8'hFF, 0, 0, 1234, 0);
        tbl[10] = mk(4'hF, 8'hFF, 0, 1, 1234, 0);
        tbl[11] = mk(4'hF, 8'hFF, 0, 0, 1234, 0);
        tbl[12] = mk(4'hD, dg(1), 0, 0, 1234, 0);
        tbl[13] = mk(4'hB, dg(2), 0, 0, 1234, 0);
        tbl[14] = mk(4'h7, dg(3), 0, 0, 1234, 0);
        tbl[15] = mk(4'hF, 8'hFF, 0, 0, 1234, 0);
        tbl[16] = mk(4'hF, 8'hFF, 0, 0, 1234, 0);
        tbl[17] = mk(4'hE, dg(7), 0, 0, 1234, 0);
        tbl[18] = mk(4'hB, dg(8), 0, 0, 1234, 0);
        tbl[19] = mk(4'hE, dg(3), 0, 1, 1234, 0);
        tbl[20] = mk(4'hD, dg(0), 0, 0, 1234, 0);
        tbl[21] = mk(4'hB, dg(0), 0, 0, 1234, 0);
        tbl[22] = mk(4'h7, dg(0), 0, 0, 1234, 0);
        tbl[23] = mk(4'hF, 8'hFF, 0, 0, 1234, 0);
        tbl[24] = mk(4'hF, 8'hFF, 1, 0, 3, 0);

        reset = 1'b1;
        tick(); tick();
        check("reset_pts",    32'(pts),        32'd0);
        check("reset_valid",  32'(pts_valid),  32'd0);
        check("reset_stable", 32'(pts_stable), 32'd0);
        check("reset_err",    32'(frame_err),  32'd0);
        reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            an = tbl[i].an; seg = tbl[i].seg;
            tick();
            check($sformatf("vec%0d", i), pack(pts_valid, frame_err, pts_stable, int'(pts)),
                  pack(tbl[i].valid, tbl[i].err, tbl[i].stable, tbl[i].pts));
        end

        // Stability: 9999, 9999, 0042
        nv0 = nv;
        send_frame(9999, 1, 0, t3);
        check("stab1_pts", 32'(pts), 32'd9999);
        check("stab1_stable", 32'(pts_stable), 32'd0);
        check("stab1_latency", 32'(vcyc), 32'(t3 + 2));
        send_frame(9999, 1, 1, t3);
        check("stab2_stable", 32'(pts_stable), 32'd1);
        send_frame(42, 1, 0, t3);
        check("stab3_stable", 32'(pts_stable), 32'd0);
        check("stab3_pts", 32'(pts), 32'd42);
        check("stab_pulses", 32'(nv - nv0), 32'd3);

        // Reset in the middle of a frame
        nv0 = nv; ne0 = ne;
        an = 4'hE; seg = dg(5); tick();
        an = 4'hD; seg = dg(6); tick();
        reset = 1'b1; an = 4'hF; seg = 8'hFF; tick();
        reset = 1'b0;
        an = 4'hB; seg = dg(7); tick();
        an = 4'h7; seg = dg(8); tick();
        idle(4);
        check("midreset_valid", 32'(nv - nv0), 32'd0);
        check("midreset_err", 32'(ne - ne0), 32'd0);
        check("midreset_pts", 32'(pts), 32'd0);

        // Held strobes with idle gaps
        nv0 = nv;
        send_frame(1234, 3, 2, t3);
        check("held_pts", 32'(pts), 32'd1234);
        check("held_pulses", 32'(nv - nv0), 32'd1);
        check("held_latency", 32'(vcyc), 32'(t3 + 2));

        // Random frames with occasional faults
        begin
            int p, last_v, v, pw, dgt, fault, reps, gap;
            logic [3:0] a;
            logic [7:0] s;
            p = 0; last_v = 1234;
            while (p < c_L) begin
                v = ($urandom_range(0, 2) == 0) ? last_v :
                    (($urandom_range(0, 1) == 0) ? 42 : int'($urandom_range(0, 9999)));
                last_v = v;
                for (int k = 0; k < 4; k++) begin
                    pw = 1;
                    for (int j = 0; j < k; j++) pw *= 10;
                    dgt = (v / pw) % 10;
                    a = ~(4'b0001 << k);
                    s = {1'b1, pat[dgt]};
                    fault = $urandom_range(0, 15);
                    if (fault == 0) a = 4'($urandom);
                    else if (fault == 1) s[6:0] = 7'b0001000;
                    else if (fault == 2) s[7] = 1'b0;
                    reps = $urandom_range(1, 3);
                    gap  = $urandom_range(0, 2);
                    for (int r = 0; r < reps; r++) begin
                        if (p < c_L) begin
                            ran[p] = a; rseg[p] = (r == 0) ? s : 8'($urandom); p++;
                        end
                    end
                    for (int g = 0; g < gap; g++) begin
                        if (p < c_L) begin
                            ran[p] = 4'hF; rseg[p] = 8'($urandom); p++;
                        end
                    end
                end
            end
            for (int i = c_L; i < c_LT; i++) begin ran[i] = 4'hF; rseg[i] = 8'hFF; end
        end

        begin
            int part[$];
            int k, dv, val, cnt, last;
            logic [3:0] prev;
            logic good;
            for (int i = 0; i < c_LT + 3; i++) begin
                e_pset[i] = 0; e_pval[i] = 0; e_err[i] = 0; e_sset[i] = 0; e_sval[i] = 0;
            end
            prev = 4'hF; cnt = 0; last = 0;
            for (int i = 0; i < c_LT; i++) begin
                k = -1;
                for (int kk = 0; kk < 4; kk++) if (ran[i] == ~(4'b0001 << kk)) k = kk;
                dv = decode(rseg[i][6:0]);
                good = (dv >= 0) && rseg[i][7];
                if (k >= 0 && ran[i] != prev) begin
                    if (part.size() == 0) begin
                        if (k == 0 && good) part.push_back(dv);
                    end else if (k == part.size() && good) begin
                        part.push_back(dv);
                        if (part.size() == 4) begin
                            val = part[0] + 10 * part[1] + 100 * part[2] + 1000 * part[3];
                            cnt = (val == last) ? ((cnt + 1 > c_S) ? c_S : cnt + 1) : 1;
                            last = val;
                            e_pset[i + 2] = 1; e_pval[i + 2] = val;
                            e_sset[i + 2] = 1; e_sval[i + 2] = (cnt == c_S);
                            part.delete();
                        end
                    end else begin
                        cnt = 0;
                        e_err[i + 1] = 1; e_sset[i + 1] = 1; e_sval[i + 1] = 0;
                        part.delete();
                        if (k == 0 && good) part.push_back(dv);
                    end
                end else if (k < 0 && ran[i] != 4'hF && part.size() != 0) begin
                    cnt = 0;
                    e_err[i + 1] = 1; e_sset[i + 1] = 1; e_sval[i + 1] = 0;
                    part.delete();
                end
                prev = ran[i];
            end
        end

        reset = 1'b1; an = 4'hF; seg = 8'hFF;
        tick(); tick();
        reset = 1'b0;
        begin
            int m_pts;
            logic m_stab;
            m_pts = 0; m_stab = 0;
            for (int i = 0; i < c_LT; i++) begin
                an = ran[i]; seg = rseg[i];
                tick();
                if (e_pset[i]) m_pts = e_pval[i];
                if (e_sset[i]) m_stab = e_sval[i];
                check($sformatf("rand%0d", i), pack(pts_valid, frame_err, pts_stable, int'(pts)),
                      pack(e_pset[i], e_err[i], m_stab, m_pts));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
